hex_display_bank: RTL and testbench
===================================

Name: hex_display_bank

Overview:
- Parametrised multi-digit successor to the single-nibble seven-segment decoder.
- Latches a DIGITS-wide hex word on a load strobe and drives DIGITS registered, active-low seven-segment outputs. Each output pins directly to a board HEX display.
- Adds leading-zero blanking and per-digit blinking from an internal prescaler.
- Sits between game/score logic and the board HEX pins.

Parameters:
- DIGITS, 4: number of nibbles/displays driven; legal 1..8.
- BLINK_DIV, 25000000: clock cycles per blink half-period (0.5 s at 50 MHz); legal >= 1.
- CNT_W, $clog2(BLINK_DIV)+1: prescaler width; derived, not overridden.

Ports:
- clock  in  1  system clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- load  in  1  sample value into the held register this cycle.
- value  in  4*DIGITS  hex word; nibble i = value[4i+3:4i], digit 0 = least significant.
- blank_lz  in  1  enable leading-zero blanking.
- blink_mask  in  DIGITS  bit i = 1 makes digit i blink.
- blink_en  in  1  run the blink prescaler.
- segments_out  out  7*DIGITS  digit i = segments_out[7i+6:7i], active-low, bit order g..a (bit 0 = a).
- blink_phase  out  1  current blink phase; 1 = visible half.

Behaviour:
- Reset (asynchronous, resetn low):
  - held = 0, prescaler = 0, blink_phase = 1.
  - segments_out = all ones (every segment off).
  - Release is synchronous to the next clock edge.
- Load:
  - load=1 at edge n → held = value at edge n.
  - segments_out reflects the new held value at edge n+1, so load-to-display latency is 2 edges.
  - load=0 → held unchanged.
  - Back-to-back loads are legal; each one is displayed one edge after it is captured.
- Decode: per-nibble table, active-low g..a:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0011000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
  - blank = 1111111.
- Leading-zero blanking (blank_lz=1):
  - Digit i is blank iff held nibbles i..DIGITS-1 are all zero and i != 0.
  - Digit 0 always shows, so held=0 displays a single "0".
  - blank_lz=0: all digits are decoded.
  - blank_lz is sampled combinationally into the segment register, so a change shows one edge later.
- Blink prescaler:
  - blink_en=1: the prescaler increments each edge. On the edge where prescaler = BLINK_DIV-1 it wraps to 0 and blink_phase toggles.
  - BLINK_DIV=1: blink_phase toggles every edge.
  - blink_en=0: prescaler is cleared to 0 and blink_phase is forced to 1 on the next edge.
- Blink masking: digit i is blank when blink_mask[i]=1 and blink_phase=0. This takes precedence over decode.
- Final segment value per digit = blank if (lz-blank OR blink-blank), else decoded. It is registered on every edge.
- Simultaneous load and prescaler wrap: both take effect in the same edge, independently. The new value is displayed at n+1 using the blink_phase value in effect at n+1.
- No handshake back-pressure; load is always accepted.

Optional Feature:
- Macro: HEX_DISPLAY_BCD_CLAMP_EN.
- Defined: any held nibble > 9 decodes to a dash (0111111) instead of A–F, for decimal-only score displays. Leading-zero logic is unchanged; a dash nibble counts as non-zero.
- Undefined: full hex decode as tabled above.

Decomposition:
- Package hex_display_pkg holds:
  - SEG_W = 7
  - SEG_BLANK = 7'b1111111
  - SEG_DASH = 7'b0111111
  - 16-entry segment constant table
  - typedef seg_t (7-bit)
- Sub-module seg7_decode (combinational nibble → seg_t, honours the clamp macro), instantiated DIGITS times via generate.
- Prescaler, held register, blanking logic and output registers stay in hex_display_bank.

Test Plan:
- Reset: assert resetn=0 mid-count with blink_en=1 → segments_out = all ones and blink_phase=1 immediately. After release with no load, the next edge shows held=0: digit 0 = 1000000 and, with blank_lz=0, all four digits = 1000000.
- Load latency: DIGITS=4, load=1 with value=16'h3A0F at edge n → segments_out unchanged at n. At n+1 the digits read d3=0110000, d2=0001000, d1=1000000, d0=0001110.
- Leading-zero blanking: blank_lz=1, load 16'h0050 → d3=d2 blank, d1=0010010, d0=1000000. Load 16'h0000 → d3..d1 blank, d0=1000000.
- Blink timing: BLINK_DIV=4, blink_en=1, blink_mask=4'b0001, held=16'h1234:
  - blink_phase toggles every 4 edges.
  - d0 alternates 0011001 and blank, lagging the phase by one edge; d3..d1 stay steady.
  - Dropping blink_en forces blink_phase=1 within one edge.
- Simultaneous events: BLINK_DIV=4, a load of 16'hFFFF coincides with the prescaler wrap to phase 0, blink_mask=4'b1111 → next edge all digits blank. Four edges later all digits = 0001110.
- Clamp macro defined: load 16'h9A0C, blank_lz=0 → d3=0011000, d2=0111111, d1=1000000, d0=0111111.

Source files
------------

// File: rtl/hex_display_pkg.sv
// hex_display_pkg: shared segment types and the active-low g..a decode table
package hex_display_pkg;
    localparam int SEG_W = 7;
    typedef logic [SEG_W-1:0] seg_t;
    localparam seg_t SEG_BLANK = 7'b1111111;
    localparam seg_t SEG_DASH  = 7'b0111111;
    localparam seg_t SEG_TABLE [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };
endpackage

// File: rtl/hex_display_bank_seg7_decode.sv
// seg7_decode: nibble to active-low segments; HEX_DISPLAY_BCD_CLAMP_EN turns A-F into a dash
module seg7_decode
    import hex_display_pkg::*;
(
    input  logic [3:0] nibble,
    output seg_t       seg
);
    // table lookup, optionally clamped to decimal digits
    always_comb begin
`ifdef HEX_DISPLAY_BCD_CLAMP_EN
        seg = (nibble > 4'd9) ? SEG_DASH : SEG_TABLE[nibble];
`else
        seg = SEG_TABLE[nibble];
`endif
    end
endmodule

// File: rtl/hex_display_bank.sv
// hex_display_bank: held hex word -> registered seven-segment digits with leading-zero blanking and blink (optional HEX_DISPLAY_BCD_CLAMP_EN)
module hex_display_bank
    import hex_display_pkg::*;
#(
    parameter  int DIGITS    = 4,
    parameter  int BLINK_DIV = 25000000,
    localparam int CNT_W     = $clog2(BLINK_DIV) + 1
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic                  blank_lz,
    input  logic [DIGITS-1:0]     blink_mask,
    input  logic                  blink_en,
    output logic [7*DIGITS-1:0]   segments_out,
    output logic                  blink_phase
);
    logic [4*DIGITS-1:0] held;
    logic [CNT_W-1:0]    cnt;
    logic [7*DIGITS-1:0] next_seg;

    for (genvar i = 0; i < DIGITS; i++) begin : g_dig
        seg_t dec;
        logic lz;
        seg7_decode u_dec (.nibble(held[4*i+:4]), .seg(dec));
        // digit 0 never blanks, so an all-zero word still shows one "0"
        assign lz = blank_lz && (i != 0) && (held[4*DIGITS-1:4*i] == '0);
        assign next_seg[7*i+:7] = (lz || (blink_mask[i] && !blink_phase)) ? SEG_BLANK : dec;
    end

    // capture the displayed word on load
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) held <= '0;
        else if (load) held <= value;
    end

    // blink prescaler: phase toggles every BLINK_DIV edges, held visible while disabled
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cnt         <= '0;
            blink_phase <= 1'b1;
        end else if (!blink_en) begin
            cnt         <= '0;
            blink_phase <= 1'b1;
        end else if (cnt == CNT_W'(BLINK_DIV - 1)) begin
            cnt         <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            cnt         <= cnt + CNT_W'(1);
        end
    end

    // register the final segment pattern every edge
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) segments_out <= '1;
        else segments_out <= next_seg;
    end
endmodule

// File: tb/tb_hex_display_bank.sv
// tb_hex_display_bank: scoreboard bench for hex_display_bank (DIGITS=4, BLINK_DIV=4)
module tb_hex_display_bank;
    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] B  = 7'b1111111;
`ifdef HEX_DISPLAY_BCD_CLAMP_EN
    localparam logic [6:0] SA = 7'b0111111;
    localparam logic [6:0] SF = 7'b0111111;
`else
    localparam logic [6:0] SA = 7'b0001000;
    localparam logic [6:0] SF = 7'b0001110;
`endif

    typedef struct {
        int          at;
        logic [27:0] seg;
        logic        ph;
        string       nm;
    } exp_t;

    logic        clock = 1'b0;
    logic        resetn, load, blank_lz, blink_en;
    logic [15:0] value;
    logic [3:0]  blink_mask;
    logic [27:0] segments_out;
    logic        blink_phase;

    exp_t q[$];
    int   cyc = 0;
    int   vecs = 0;
    int   errs = 0;

    hex_display_bank #(.DIGITS(4), .BLINK_DIV(4)) dut (
        .clock(clock), .resetn(resetn), .load(load), .value(value),
        .blank_lz(blank_lz), .blink_mask(blink_mask), .blink_en(blink_en),
        .segments_out(segments_out), .blink_phase(blink_phase)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    task automatic chk(input string nm, input logic [27:0] act, input logic [27:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    task automatic expect_at(input int at, input logic [27:0] s, input logic ph, input string nm);
        exp_t e;
        e.at = at; e.seg = s; e.ph = ph; e.nm = nm;
        q.push_back(e);
    endtask

    function automatic logic ph_of(input int j);
        return ((j >> 2) & 1) == 0;
    endfunction

    always @(negedge clock) begin
        while (q.size() > 0 && q[0].at <= cyc) begin
            exp_t e;
            e = q.pop_front();
            if (e.at < cyc) begin
                vecs++;
                errs++;
                $display("FAIL %s: missed check at cyc %0d (now %0d)", e.nm, e.at, cyc);
            end else begin
                chk({e.nm, "_seg"}, segments_out, e.seg);
                chk({e.nm, "_phase"}, {27'd0, blink_phase}, {27'd0, e.ph});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int k;
        resetn = 0; load = 0; value = '0; blank_lz = 0; blink_mask = '0; blink_en = 1;
        repeat (2) @(negedge clock);
        resetn = 1;
        repeat (3) @(negedge clock);
        #2 resetn = 0;
        #1;
        chk("reset_seg", segments_out, '1);
        chk("reset_phase", {27'd0, blink_phase}, 28'd1);
        @(negedge clock);
        resetn = 1; blink_en = 0;
        expect_at(cyc + 1, {4{S0}}, 1'b1, "post_reset");
        @(negedge clock);

        k = cyc;
        load = 1; value = 16'h3A0F;
        expect_at(k + 1, {4{S0}}, 1'b1, "load_hold");
        expect_at(k + 2, {S3, SA, S0, SF}, 1'b1, "load_3A0F");
        @(negedge clock);
        load = 0;
        @(negedge clock);

        k = cyc;
        blank_lz = 1; load = 1; value = 16'h0050;
        expect_at(k + 2, {B, B, S5, S0}, 1'b1, "lz_0050");
        @(negedge clock);
        load = 0;
        @(negedge clock);
        k = cyc;
        load = 1; value = 16'h0000;
        expect_at(k + 2, {B, B, B, S0}, 1'b1, "lz_0000");
        @(negedge clock);
        load = 0;
        @(negedge clock);
        blank_lz = 0;
        expect_at(cyc + 1, {4{S0}}, 1'b1, "lz_off");
        @(negedge clock);

        k = cyc;
        load = 1; value = 16'h1234; blink_mask = 4'b0001; blink_en = 1;
        for (int j = 2; j <= 12; j++)
            expect_at(k + j, {S1, S2, S3, ph_of(j - 1) ? S4 : B}, ph_of(j), "blink");
        @(negedge clock);
        load = 0;
        repeat (12) @(negedge clock);
        blink_en = 0;
        expect_at(k + 14, {S1, S2, S3, B}, 1'b1, "blink_off");
        expect_at(k + 15, {S1, S2, S3, S4}, 1'b1, "blink_off_vis");
        repeat (2) @(negedge clock);

        k = cyc;
        blink_en = 1; blink_mask = 4'hF;
        expect_at(k + 4, {S1, S2, S3, S4}, 1'b0, "sim_pre");
        expect_at(k + 5, {4{B}}, 1'b0, "sim_blank");
        expect_at(k + 8, {4{B}}, 1'b1, "sim_still_blank");
        expect_at(k + 9, {4{SF}}, 1'b1, "sim_FFFF");
        repeat (3) @(negedge clock);
        load = 1; value = 16'hFFFF;
        @(negedge clock);
        load = 0;
        repeat (7) @(negedge clock);

        vecs++;
        if (q.size() != 0) begin
            errs++;
            $display("FAIL pending: got %0d unchecked entries expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
